// File: rtl/vr_fifo_pkg.sv
// Shared types and helpers for the valid/ready synchronous FIFO.
package vr_fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MID   = 2'd1,
    S_FULL  = 2'd2
  } fifo_state_t;

  // Pointer width: index bits plus one wrap flag, which also sizes the occupancy count.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vr_fifo_mem.sv
// FIFO storage: DEPTH x DW register array, one write port, one asynchronous read port.
// Contents are not reset; validity is tracked entirely by the pointers in the parent.
module vr_fifo_mem
  import vr_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = ptr_w(DEPTH) - 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write the accepted word into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vr_sync_fifo.sv
// Synchronous valid/ready FIFO, first-word-fall-through, single clock.
// s_ready and m_valid come from registered state so there is no combinational
// path from m_ready to s_ready. Occupancy and an almost-full flag are exported.
// Optional macro VR_FIFO_BYPASS_EN: when empty, a word offered while the sink is
// ready passes straight through to the output in the same cycle without being stored.
//
//  state   | meaning
//  S_EMPTY | no entries, accepting, head invalid
//  S_MID   | 1..DEPTH-1 entries, accepting, head valid
//  S_FULL  | DEPTH entries, not accepting, head valid
module vr_sync_fifo
  import vr_fifo_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DW-1:0]          s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW-1:0]          m_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   afull
);

  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  fifo_state_t   state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          s_ready_q;
  logic          m_valid_q;
  logic          afull_q;
  logic          full_d;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [DW-1:0] mem_rdata;

`ifdef VR_FIFO_BYPASS_EN
  assign bypass = (state_q == S_EMPTY) & s_ready_q & rstn & s_valid & m_ready;
`else
  assign bypass = 1'b0;
`endif

  // Flags are forced low while reset is held, even before the reset edge lands.
  assign s_ready = s_ready_q & rstn;
  assign m_valid = (m_valid_q | bypass) & rstn;
  assign afull   = afull_q & rstn;
  assign m_data  = bypass ? s_data : mem_rdata;
  assign count   = count_q;

  // A bypassed word goes straight to the sink, so it is neither stored nor counted.
  assign push = s_valid & s_ready & ~bypass;
  assign pop  = m_valid_q & rstn & m_ready;

  vr_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[IW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr_q[IW-1:0]),
    .rdata (mem_rdata)
  );

  // Next pointers, occupancy and state from this cycle's push/pop.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + PW'(1);
    end else if (pop && !push) begin
      count_d = count_q - PW'(1);
    end

    // Full when indices coincide but the wrap flags differ.
    full_d = (wr_ptr_d[IW-1:0] == rd_ptr_d[IW-1:0]) && (wr_ptr_d[IW] != rd_ptr_d[IW]);

    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d = S_MID;
        end
      end
      S_MID: begin
        if (push && !pop && full_d) begin
          state_d = S_FULL;
        end else if (pop && !push && (count_q == PW'(1))) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_MID;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state with registered handshake and almost-full flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != S_FULL);
      m_valid_q <= (state_d != S_EMPTY);
      afull_q   <= (count_d >= PW'(AFULL_TH));
    end
  end

endmodule

// File: tb/tb_vr_sync_fifo.sv
// Self-checking bench for vr_sync_fifo (DW=32, DEPTH=8, AFULL_TH=6).
module tb_vr_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [3:0]    count;
  logic          afull;

  int tests = 0;
  int fails = 0;

  vr_sync_fifo #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AFULL_TH (6)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count),
    .afull   (afull)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic        chk_md;
    logic [31:0] e_md;
    logic [3:0]  e_cnt;
    logic        e_af;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic mr, logic e_sr, logic e_mv,
                              logic chk_md, logic [31:0] e_md, int e_cnt, logic e_af);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.e_sr = e_sr; v.e_mv = e_mv;
    v.chk_md = chk_md; v.e_md = e_md; v.e_cnt = 4'(e_cnt); v.e_af = e_af;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic        exp_sr, exp_mv, exp_byp, sr_prev;
  int          pv, pr;

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h55;
    m_ready = 1'b0;

    // Reset held for three cycles with a source offering data.
    repeat (3) step();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_afull",   32'(afull),   32'd0);
    rstn    = 1'b1;
    s_valid = 1'b0;
    step();
    chk("rel_s_ready", 32'(s_ready), 32'd1);
    chk("rel_m_valid", 32'(m_valid), 32'd0);
    chk("rel_count",   32'(count),   32'd0);

    // Fill 0x01..0x08 with sink stalled; afull from count 6.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 32'(i + 1), 1'b0, 1'b1, (i > 0), (i > 0), 32'h01, i, (i >= 6)));
    // Ninth word offered while full: refused, count stays 8.
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1'b1, 32'h09, 1'b0, 1'b0, 1'b1, 1'b1, 32'h01, 8, 1'b1));
    // Drain in order.
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(1'b0, 32'h0, 1'b1, (j > 0), 1'b1, 1'b1, 32'(j + 1), 8 - j, ((8 - j) >= 6)));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0));
    // Preload four words, then 20 cycles of simultaneous push/pop across the wrap.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1'b1, 32'(16 + k), 1'b0, 1'b1, (k > 0), (k > 0), 32'h10, k, 1'b0));
    for (int k = 0; k < 20; k++)
      vecs.push_back(mk(1'b1, 32'(20 + k), 1'b1, 1'b1, 1'b1, 1'b1, 32'(16 + k), 4, 1'b0));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'(36 + j), 4 - j, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0));

    foreach (vecs[n]) begin
      s_valid = vecs[n].sv;
      s_data  = vecs[n].sd;
      m_ready = vecs[n].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", n), 32'(s_ready), 32'(vecs[n].e_sr));
      chk($sformatf("vec%0d_m_valid", n), 32'(m_valid), 32'(vecs[n].e_mv));
      chk($sformatf("vec%0d_count", n),   32'(count),   32'(vecs[n].e_cnt));
      chk($sformatf("vec%0d_afull", n),   32'(afull),   32'(vecs[n].e_af));
      if (vecs[n].chk_md)
        chk($sformatf("vec%0d_m_data", n), m_data, vecs[n].e_md);
      step();
    end

    // Empty FIFO, word offered with sink ready: bypass or one-cycle latency.
    s_valid = 1'b1;
    s_data  = 32'hA5;
    m_ready = 1'b1;
    @(negedge clk);
`ifdef VR_FIFO_BYPASS_EN
    chk("byp_m_valid", 32'(m_valid), 32'd1);
    chk("byp_m_data",  m_data,       32'hA5);
    chk("byp_count",   32'(count),   32'd0);
`else
    chk("lat_m_valid0", 32'(m_valid), 32'd0);
    chk("lat_count0",   32'(count),   32'd0);
`endif
    step();
    s_valid = 1'b0;
    @(negedge clk);
`ifdef VR_FIFO_BYPASS_EN
    chk("byp_m_valid1", 32'(m_valid), 32'd0);
    chk("byp_count1",   32'(count),   32'd0);
`else
    chk("lat_m_valid1", 32'(m_valid), 32'd1);
    chk("lat_m_data1",  m_data,       32'hA5);
    chk("lat_count1",   32'(count),   32'd1);
`endif
    step();
    chk("lat_count2",   32'(count),   32'd0);
    chk("lat_m_valid2", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // Reset in the middle of operation discards stored words.
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = 32'(49 + k);
      step();
    end
    chk("mid_pre_count", 32'(count), 32'd3);
    rstn    = 1'b0;
    s_data  = 32'h34;
    m_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    step();
    chk("mid_rst_count", 32'(count), 32'd0);
    rstn    = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    step();
    chk("mid_rel_s_ready", 32'(s_ready), 32'd1);
    chk("mid_rel_m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1;
    s_data  = 32'h77;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("mid_new_m_data", m_data,       32'h77);
    chk("mid_new_count",  32'(count),   32'd1);
    m_ready = 1'b1;
    step();
    chk("mid_pop_count",   32'(count),   32'd0);
    chk("mid_pop_m_valid", 32'(m_valid), 32'd0);

    // Random backpressure against a queue model; source holds data while refused.
    q.delete();
    sr_prev = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      case ((c / 1000) % 3)
        0:       begin pv = 80; pr = 30; end
        1:       begin pv = 30; pr = 80; end
        default: begin pv = 60; pr = 60; end
      endcase
      if (!(s_valid && !sr_prev)) begin
        s_valid = ($urandom_range(99) < pv);
        s_data  = $urandom;
      end
      m_ready = ($urandom_range(99) < pr);
      @(negedge clk);
`ifdef VR_FIFO_BYPASS_EN
      exp_byp = (q.size() == 0) && s_valid && m_ready;
`else
      exp_byp = 1'b0;
`endif
      exp_mv = (q.size() != 0) || exp_byp;
      exp_sr = (q.size() < DEPTH);
      chk("rnd_m_valid", 32'(m_valid), 32'(exp_mv));
      chk("rnd_s_ready", 32'(s_ready), 32'(exp_sr));
      chk("rnd_count",   32'(count),   32'(q.size()));
      if (exp_mv && m_valid)
        chk("rnd_m_data", m_data, exp_byp ? s_data : q[0]);
      if ((q.size() != 0) && m_ready)
        void'(q.pop_front());
      if (s_valid && exp_sr && !exp_byp)
        q.push_back(s_data);
      sr_prev = exp_sr;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
